// File: rtl/ps2_host_ctrl_if.sv
// ----------------------------------------------------------------------------
// ps2_host_ctrl_if
// Command and receive bus between the PS/2 host controller and its user.
//   cmd_valid / cmd_byte / cmd_ready : command byte handshake (user -> ctrl)
//   cmd_done / cmd_err               : 1-cycle command outcome pulses
//   rx_valid / rx_byte / rx_err      : received device traffic
//   init_done                        : power-up sequence finished (level)
// Modports: master = user side (game/top-level), slave = controller side.
// ----------------------------------------------------------------------------
interface ps2_host_ctrl_if;
  logic       cmd_valid;
  logic [7:0] cmd_byte;
  logic       cmd_ready;
  logic       cmd_done;
  logic       cmd_err;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_err;
  logic       init_done;

  modport master (
    output cmd_valid, cmd_byte,
    input  cmd_ready, cmd_done, cmd_err, rx_valid, rx_byte, rx_err, init_done
  );

  modport slave (
    input  cmd_valid, cmd_byte,
    output cmd_ready, cmd_done, cmd_err, rx_valid, rx_byte, rx_err, init_done
  );
endinterface

// File: rtl/ps2_host_ctrl.sv
// ----------------------------------------------------------------------------
// ps2_host_ctrl
// Bidirectional PS/2 host controller. Receives device frames, sends host
// commands with inhibit / request-to-send, checks the line ACK bit and the
// device FA/FE response, retries on FE, and optionally runs a reset (FF)
// power-up sequence that waits for FA then AA.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   ps2_clk_i     PS/2 clock line read-back (asynchronous)
//   ps2_data_i    PS/2 data line read-back (asynchronous)
//   ps2_clk_oe    1 = pull PS/2 clock low
//   ps2_data_oe   1 = pull PS/2 data low
//   bus           ps2_host_ctrl_if.slave command / receive bus
// ----------------------------------------------------------------------------
module ps2_host_ctrl #(
  parameter int INHIBIT_CYC = 2500,
  parameter int TIMEOUT_CYC = 250000,
  parameter int MAX_RETRY   = 3,
  parameter int INIT_RESET  = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ps2_clk_i,
  input  logic           ps2_data_i,
  output logic           ps2_clk_oe,
  output logic           ps2_data_oe,
  ps2_host_ctrl_if.slave bus
);

  localparam int TMAX = (TIMEOUT_CYC > INHIBIT_CYC) ? TIMEOUT_CYC : INHIBIT_CYC;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int RW   = $clog2(MAX_RETRY + 2);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] INHIBIT_LAST = TW'(INHIBIT_CYC - 1);
  localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RX       = 3'd1,
    ST_INHIBIT  = 3'd2,
    ST_RTS      = 3'd3,
    ST_TX       = 3'd4,
    ST_TX_ACK   = 3'd5,
    ST_WAIT_RSP = 3'd6
  } state_t;

  // Odd parity bit for a data byte (parity makes the total count of ones odd).
  function automatic logic odd_par(input logic [7:0] b);
    return ~^b;
  endfunction

  // Frame layout: [0]=start, [8:1]=data, [9]=parity, [10]=stop.
  function automatic logic frame_ok(input logic [10:0] f);
    return (f[0] == 1'b0) && (f[10] == 1'b1) && (odd_par(f[8:1]) == f[9]);
  endfunction

  logic          clk_meta_r, clk_sync_r, clk_prev_r;
  logic          data_meta_r, data_sync_r;
  logic          fall_s;
  logic          last_bit_s;
  logic          timeout_s;
  logic [10:0]   frame_s;

  state_t        state_r;
  logic [9:0]    shift_r;
  logic [3:0]    bit_cnt_r;
  logic [TW-1:0] timer_r;
  logic [RW-1:0] retry_r;
  logic [7:0]    cmd_byte_r;
  logic          clk_oe_r, data_oe_r;
  logic          cmd_ready_r, cmd_done_r, cmd_err_r;
  logic          rx_valid_r, rx_err_r;
  logic [7:0]    rx_byte_r;
  logic          init_done_r;  // sticky until rst
  logic          init_cmd_r;   // current transaction is the power-up FF
  logic          init_aa_r;    // FF acknowledged with FA, waiting for AA
  logic          init_wait_r;  // power-up failed, re-run FF after a timeout

  // Two-flop synchronisers plus previous clock sample for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      clk_prev_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
    end else begin
      clk_meta_r  <= ps2_clk_i;
      clk_sync_r  <= clk_meta_r;
      clk_prev_r  <= clk_sync_r;
      data_meta_r <= ps2_data_i;
      data_sync_r <= data_meta_r;
    end
  end

  assign fall_s     = clk_prev_r & ~clk_sync_r;
  assign frame_s    = {data_sync_r, shift_r};
  assign last_bit_s = (bit_cnt_r == 4'd10);
  assign timeout_s  = (timer_r == TIMEOUT_LAST);

  // Abandon the current command: release both lines and report cmd_err.
  // A failed power-up transaction arms the delayed FF re-run.
  task automatic fail_cmd();
    clk_oe_r    <= 1'b0;
    data_oe_r   <= 1'b0;
    cmd_err_r   <= 1'b1;
    timer_r     <= {TW{1'b0}};
    bit_cnt_r   <= 4'd0;
    init_wait_r <= init_cmd_r;
    init_cmd_r  <= 1'b0;
    init_aa_r   <= 1'b0;
    state_r     <= ST_IDLE;
  endtask

  // Main controller FSM with registered line drivers and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= (INIT_RESET != 0) ? ST_INHIBIT : ST_IDLE;
      shift_r     <= 10'd0;
      bit_cnt_r   <= 4'd0;
      timer_r     <= {TW{1'b0}};
      retry_r     <= {RW{1'b0}};
      cmd_byte_r  <= 8'hFF;
      clk_oe_r    <= 1'b0;
      data_oe_r   <= 1'b0;
      cmd_ready_r <= 1'b0;
      cmd_done_r  <= 1'b0;
      cmd_err_r   <= 1'b0;
      rx_valid_r  <= 1'b0;
      rx_err_r    <= 1'b0;
      rx_byte_r   <= 8'h00;
      init_done_r <= (INIT_RESET == 0) ? 1'b1 : 1'b0;
      init_cmd_r  <= (INIT_RESET != 0) ? 1'b1 : 1'b0;
      init_aa_r   <= 1'b0;
      init_wait_r <= 1'b0;
    end else begin
      cmd_ready_r <= 1'b0;
      cmd_done_r  <= 1'b0;
      cmd_err_r   <= 1'b0;
      rx_valid_r  <= 1'b0;
      rx_err_r    <= 1'b0;
      timer_r     <= timer_r + {{(TW-1){1'b0}}, 1'b1};
      case (state_r)
        ST_IDLE: begin
          clk_oe_r  <= 1'b0;
          data_oe_r <= 1'b0;
          // cmd_ready_r is only ever 1 after a full idle cycle, so a
          // handshake here always refers to the byte presented now.
          if (bus.cmd_valid && cmd_ready_r) begin
            cmd_byte_r <= bus.cmd_byte;
            retry_r    <= {RW{1'b0}};
            init_cmd_r <= 1'b0;
            clk_oe_r   <= 1'b1;
            timer_r    <= {TW{1'b0}};
            state_r    <= ST_INHIBIT;
          end else if (fall_s) begin
            shift_r   <= {data_sync_r, shift_r[9:1]};
            bit_cnt_r <= 4'd1;
            timer_r   <= {TW{1'b0}};
            state_r   <= ST_RX;
          end else if (init_wait_r) begin
            if (timer_r == TIMEOUT_LAST) begin
              init_wait_r <= 1'b0;
              init_cmd_r  <= 1'b1;
              cmd_byte_r  <= 8'hFF;
              retry_r     <= {RW{1'b0}};
              clk_oe_r    <= 1'b1;
              timer_r     <= {TW{1'b0}};
              state_r     <= ST_INHIBIT;
            end
          end else begin
            cmd_ready_r <= init_done_r;
          end
        end

        ST_RX: begin
          if (fall_s) begin
            timer_r <= {TW{1'b0}};
            if (last_bit_s) begin
              bit_cnt_r <= 4'd0;
              state_r   <= ST_IDLE;
              if (frame_ok(frame_s)) begin
                rx_valid_r <= 1'b1;
                rx_byte_r  <= frame_s[8:1];
              end else begin
                rx_err_r <= 1'b1;
              end
            end else begin
              shift_r   <= {data_sync_r, shift_r[9:1]};
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end
          end else if (timeout_s) begin
            bit_cnt_r <= 4'd0;
            rx_err_r  <= 1'b1;
            timer_r   <= {TW{1'b0}};
            state_r   <= ST_IDLE;
          end
        end

        ST_INHIBIT: begin
          clk_oe_r  <= 1'b1;
          data_oe_r <= 1'b0;
          if (timer_r == INHIBIT_LAST) begin
            data_oe_r <= 1'b1;  // start bit while the clock is still held
            timer_r   <= {TW{1'b0}};
            state_r   <= ST_RTS;
          end
        end

        ST_RTS: begin
          clk_oe_r  <= 1'b0;
          data_oe_r <= 1'b1;
          timer_r   <= {TW{1'b0}};
          bit_cnt_r <= 4'd0;
          state_r   <= ST_TX;
        end

        ST_TX: begin
          // Fall k (k = bit_cnt_r+1): k=1..8 data, k=9 parity, k=10 stop.
          if (fall_s) begin
            timer_r   <= {TW{1'b0}};
            bit_cnt_r <= bit_cnt_r + 4'd1;
            if (bit_cnt_r < 4'd8) begin
              data_oe_r <= ~cmd_byte_r[bit_cnt_r[2:0]];
            end else if (bit_cnt_r == 4'd8) begin
              data_oe_r <= ~odd_par(cmd_byte_r);
            end else begin
              data_oe_r <= 1'b0;
              bit_cnt_r <= 4'd0;
              state_r   <= ST_TX_ACK;
            end
          end else if (timeout_s) begin
            fail_cmd();
          end
        end

        ST_TX_ACK: begin
          data_oe_r <= 1'b0;
          if (fall_s) begin
            timer_r <= {TW{1'b0}};
            if (!data_sync_r) begin
              bit_cnt_r <= 4'd0;
              state_r   <= ST_WAIT_RSP;
            end else begin
              fail_cmd();
            end
          end else if (timeout_s) begin
            fail_cmd();
          end
        end

        ST_WAIT_RSP: begin
          if (fall_s) begin
            timer_r <= {TW{1'b0}};
            if (last_bit_s) begin
              bit_cnt_r <= 4'd0;
              if (!frame_ok(frame_s)) begin
                rx_err_r <= 1'b1;
              end else if (init_cmd_r && (frame_s[8:1] == 8'hFC)) begin
                fail_cmd();
              end else if (init_aa_r) begin
                if (frame_s[8:1] == 8'hAA) begin
                  init_done_r <= 1'b1;
                  init_aa_r   <= 1'b0;
                  init_cmd_r  <= 1'b0;
                  state_r     <= ST_IDLE;
                end else begin
                  rx_valid_r <= 1'b1;
                  rx_byte_r  <= frame_s[8:1];
                end
              end else if (frame_s[8:1] == 8'hFA) begin
                // The power-up FF is internal: its FA only advances to AA.
                if (init_cmd_r) begin
                  init_aa_r <= 1'b1;
                end else begin
                  cmd_done_r <= 1'b1;
                  state_r    <= ST_IDLE;
                end
              end else if (frame_s[8:1] == 8'hFE) begin
                if (retry_r < RETRY_MAX) begin
                  retry_r  <= retry_r + {{(RW-1){1'b0}}, 1'b1};
                  clk_oe_r <= 1'b1;
                  state_r  <= ST_INHIBIT;
                end else begin
                  fail_cmd();
                end
              end else begin
                rx_valid_r <= 1'b1;
                rx_byte_r  <= frame_s[8:1];
              end
            end else begin
              shift_r   <= {data_sync_r, shift_r[9:1]};
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end
          end else if (timeout_s) begin
            fail_cmd();
          end
        end

        default: begin
          clk_oe_r  <= 1'b0;
          data_oe_r <= 1'b0;
          bit_cnt_r <= 4'd0;
          timer_r   <= {TW{1'b0}};
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  assign ps2_clk_oe    = clk_oe_r;
  assign ps2_data_oe   = data_oe_r;
  assign bus.cmd_ready = cmd_ready_r;
  assign bus.cmd_done  = cmd_done_r;
  assign bus.cmd_err   = cmd_err_r;
  assign bus.rx_valid  = rx_valid_r;
  assign bus.rx_byte   = rx_byte_r;
  assign bus.rx_err    = rx_err_r;
  assign bus.init_done = init_done_r;

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ps2_host_ctrl
// Directed bench: the bench plays the PS/2 keyboard on an open-collector
// line model and checks the host controller with hand-computed values.
// ----------------------------------------------------------------------------
module tb_ps2_host_ctrl;
  localparam int INHIBIT_CYC = 20;
  localparam int TIMEOUT_CYC = 1000;
  localparam int MAX_RETRY   = 3;
  localparam int HALF        = 8;

  logic clk;
  logic rst;
  logic dev_clk;
  logic dev_data;
  logic ps2_clk_oe;
  logic ps2_data_oe;
  logic line_clk;
  logic line_data;

  ps2_host_ctrl_if bus ();

  ps2_host_ctrl #(
    .INHIBIT_CYC (INHIBIT_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .MAX_RETRY   (MAX_RETRY),
    .INIT_RESET  (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk_i   (line_clk),
    .ps2_data_i  (line_data),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .bus         (bus)
  );

  // Wired-AND open-collector lines.
  assign line_clk  = dev_clk & ~ps2_clk_oe;
  assign line_data = dev_data & ~ps2_data_oe;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int cnt_done = 0, cnt_err = 0, cnt_rxv = 0, cnt_rxe = 0, cnt_multi = 0;
  int oe_run = 0, last_oe_run = 0;
  int last_fall_cyc = 0;

  // Output monitor: pulse counters and clock-inhibit run length.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      if (bus.cmd_done) cnt_done = cnt_done + 1;
      if (bus.cmd_err)  cnt_err  = cnt_err + 1;
      if (bus.rx_valid) cnt_rxv  = cnt_rxv + 1;
      if (bus.rx_err)   cnt_rxe  = cnt_rxe + 1;
      if ((int'(bus.cmd_done) + int'(bus.cmd_err) + int'(bus.rx_valid) + int'(bus.rx_err)) > 1)
        cnt_multi = cnt_multi + 1;
      if (ps2_clk_oe) oe_run = oe_run + 1;
      else if (oe_run != 0) begin
        last_oe_run = oe_run;
        oe_run = 0;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Device -> host frame; flip inverts the parity bit.
  task automatic dev_send(input logic [7:0] b, input bit flip);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ flip, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      dev_data = f[i];
      wait_cyc(HALF);
      dev_clk = 1'b0;
      wait_cyc(HALF);
      dev_clk = 1'b1;
    end
    dev_data = 1'b1;
    wait_cyc(HALF);
  endtask

  // Host -> device frame. stop_after < 10 stops clocking after that many falls.
  task automatic dev_recv(input bit ack, input int stop_after, output logic [10:0] bits);
    int n;
    n = 0;
    bits = 11'd0;
    while (!ps2_clk_oe && n < 20000) begin
      wait_cyc(1);
      n++;
    end
    check_eq("inhibit_seen", 32'(ps2_clk_oe), 32'd1);
    n = 0;
    while (ps2_clk_oe && n < 20000) begin
      wait_cyc(1);
      n++;
    end
    wait_cyc(HALF);
    bits[0] = line_data;
    for (int k = 1; k <= 10; k++) begin
      if (k <= stop_after) begin
        dev_clk = 1'b0;
        last_fall_cyc = cyc;
        wait_cyc(HALF);
        bits[k] = line_data;
        dev_clk = 1'b1;
        wait_cyc(HALF);
      end
    end
    if (stop_after >= 10) begin
      dev_data = ack ? 1'b0 : 1'b1;
      wait_cyc(2);
      dev_clk = 1'b0;
      wait_cyc(HALF);
      dev_clk = 1'b1;
      dev_data = 1'b1;
      wait_cyc(HALF);
    end
  endtask

  task automatic send_cmd(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_byte  = b;
    while (!bus.cmd_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check_eq("cmd_ready_hs", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  // One full transmission of byte exp_b with ack; checks framing and inhibit.
  task automatic recv_check(input string tag, input logic [7:0] exp_b, input logic exp_par);
    logic [10:0] bits;
    dev_recv(1'b1, 10, bits);
    check_eq({tag, "_start"}, 32'(bits[0]), 32'd0);
    check_eq({tag, "_byte"}, 32'(bits[8:1]), 32'(exp_b));
    check_eq({tag, "_par"}, 32'(bits[9]), 32'(exp_par));
    check_eq({tag, "_stop"}, 32'(bits[10]), 32'd1);
    check_eq({tag, "_inh_ok"},
             32'((last_oe_run >= INHIBIT_CYC) && (last_oe_run <= INHIBIT_CYC + 2)), 32'd1);
  endtask

  initial begin
    int d0, e0, v0, x0, n;
    logic [10:0] bits;
    rst = 1'b1;
    dev_clk = 1'b1;
    dev_data = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_byte = 8'h00;
    wait_cyc(5);
    check_eq("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check_eq("rst_data_oe", 32'(ps2_data_oe), 32'd0);
    check_eq("rst_init_done", 32'(bus.init_done), 32'd0);
    check_eq("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check_eq("rst_rx_byte", 32'(bus.rx_byte), 32'h00);
    check_eq("rst_pulses", 32'(bus.cmd_done | bus.cmd_err | bus.rx_valid | bus.rx_err), 32'd0);
    rst = 1'b0;

    // Power-up: FF (eight ones -> parity 1), then FA, then AA.
    recv_check("init_ff", 8'hFF, 1'b1);
    dev_send(8'hFA, 1'b0);
    wait_cyc(10);
    check_eq("init_mid_done", 32'(bus.init_done), 32'd0);
    check_eq("init_mid_ready", 32'(bus.cmd_ready), 32'd0);
    dev_send(8'hAA, 1'b0);
    wait_cyc(10);
    check_eq("init_done", 32'(bus.init_done), 32'd1);
    check_eq("init_ready", 32'(bus.cmd_ready), 32'd1);
    check_eq("init_no_rxv", 32'(cnt_rxv), 32'd0);

    // Scan code 1C (three ones -> parity 0).
    v0 = cnt_rxv; x0 = cnt_rxe;
    dev_send(8'h1C, 1'b0);
    wait_cyc(10);
    check_eq("rx1c_valid", 32'(cnt_rxv - v0), 32'd1);
    check_eq("rx1c_byte", 32'(bus.rx_byte), 32'h1C);
    check_eq("rx1c_no_err", 32'(cnt_rxe - x0), 32'd0);

    // Bad parity frames: dropped, rx_byte holds 1C.
    v0 = cnt_rxv; x0 = cnt_rxe;
    dev_send(8'h1C, 1'b1);
    wait_cyc(10);
    check_eq("bad1c_err", 32'(cnt_rxe - x0), 32'd1);
    check_eq("bad1c_no_valid", 32'(cnt_rxv - v0), 32'd0);
    dev_send(8'h2A, 1'b1);
    wait_cyc(10);
    check_eq("bad2a_err", 32'(cnt_rxe - x0), 32'd2);
    check_eq("bad2a_byte_held", 32'(bus.rx_byte), 32'h1C);

    // Command ED: bits 1,0,1,1,0,1,1,1 parity 1, then FA.
    d0 = cnt_done; e0 = cnt_err;
    send_cmd(8'hED);
    recv_check("ed", 8'hED, 1'b1);
    dev_send(8'hFA, 1'b0);
    wait_cyc(10);
    check_eq("ed_done", 32'(cnt_done - d0), 32'd1);
    check_eq("ed_no_err", 32'(cnt_err - e0), 32'd0);
    check_eq("ed_ready_again", 32'(bus.cmd_ready), 32'd1);

    // Command F3 (six ones -> parity 1): FE, FE, FA -> three transmissions.
    d0 = cnt_done; e0 = cnt_err;
    send_cmd(8'hF3);
    for (int i = 0; i < 3; i++) begin
      recv_check("f3_retry", 8'hF3, 1'b1);
      dev_send((i < 2) ? 8'hFE : 8'hFA, 1'b0);
    end
    wait_cyc(10);
    check_eq("f3_done", 32'(cnt_done - d0), 32'd1);
    check_eq("f3_no_err", 32'(cnt_err - e0), 32'd0);

    // FE four times: initial send + MAX_RETRY resends, then cmd_err.
    d0 = cnt_done; e0 = cnt_err;
    send_cmd(8'hF3);
    for (int i = 0; i < 4; i++) begin
      recv_check("f3_exhaust", 8'hF3, 1'b1);
      dev_send(8'hFE, 1'b0);
    end
    wait_cyc(10);
    check_eq("exhaust_err", 32'(cnt_err - e0), 32'd1);
    check_eq("exhaust_no_done", 32'(cnt_done - d0), 32'd0);
    check_eq("exhaust_idle", 32'(ps2_clk_oe | ps2_data_oe), 32'd0);

    // Missing line ACK bit -> cmd_err.
    e0 = cnt_err;
    send_cmd(8'hF4);
    dev_recv(1'b0, 10, bits);
    wait_cyc(10);
    check_eq("nack_err", 32'(cnt_err - e0), 32'd1);

    // Device stops clocking after 5 bits -> cmd_err after TIMEOUT_CYC.
    e0 = cnt_err; d0 = cnt_done;
    send_cmd(8'hF4);
    dev_recv(1'b1, 5, bits);
    n = 0;
    while (cnt_err == e0 && n < 3 * TIMEOUT_CYC) begin
      wait_cyc(1);
      n++;
    end
    check_eq("to_err", 32'(cnt_err - e0), 32'd1);
    check_eq("to_delay_ok",
             32'(((cyc - last_fall_cyc) >= TIMEOUT_CYC) && ((cyc - last_fall_cyc) <= TIMEOUT_CYC + 10)),
             32'd1);
    wait_cyc(2);
    check_eq("to_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check_eq("to_data_oe", 32'(ps2_data_oe), 32'd0);
    check_eq("to_no_done", 32'(cnt_done - d0), 32'd0);

    check_eq("pulse_exclusive", 32'(cnt_multi), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
